// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package cpu_fetch_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter with next-PC selection (hold / sequential step / redirect)
// and the redirect-target alignment check.
module fetch_pc_gen
  import cpu_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int unsigned     PC_STEP  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic            misaligned
);

  logic [PC_W-1:0] pc_next;

  assign misaligned = redirect_pc[0];

  // Next-PC mux: a misaligned redirect freezes the PC instead of loading it.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      if (!misaligned) pc_next = redirect_pc;
    end else if (advance) begin
      pc_next = pc + PC_W'(PC_STEP);
    end
  end

  // PC register, wraps modulo 2^PC_W.
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, loads the IF/ID register under
// a valid/ready handshake, handles redirects, HALT drain and misaligned
// redirect targets. Optional single-step gating: FETCH_SINGLE_STEP_EN.
module fetch_sequencer
  import cpu_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic [15:0]        imem_addr,
  input  logic [15:0]        imem_data,
  output logic               ifid_valid,
  input  logic               ifid_ready,
  output logic [15:0]        ifid_instr,
  output logic [15:0]        ifid_pc,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_pc,
  output logic               halted,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] fetch_count
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            misaligned;
  logic            step_ok;
  logic            load;
  logic            redirect_apply;

`ifdef FETCH_SINGLE_STEP_EN
  assign step_ok = !step_mode || step;
`else
  assign step_ok = 1'b1;
`endif

  assign redirect_apply = redirect_valid && (state == FETCH || state == DRAIN);
  assign load           = (state == FETCH) && (!ifid_valid || ifid_ready) && step_ok;
  assign imem_addr      = pc;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .clk         (clk),
    .reset       (reset),
    .advance     (load && !redirect_apply),
    .redirect    (redirect_apply),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .misaligned  (misaligned)
  );

  // FSM, IF/ID register and status flags; a redirect overrides load and stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ifid_valid   <= 1'b0;
      ifid_instr   <= '0;
      ifid_pc      <= '0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else if (redirect_apply) begin
      ifid_valid <= 1'b0;
      if (misaligned) begin
        misalign_err <= 1'b1;
        halted       <= 1'b1;
        state        <= HALTED;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          if (load) begin
            ifid_instr <= imem_data;
            ifid_pc    <= pc;
            ifid_valid <= 1'b1;
            if (fetch_count != '1) fetch_count <= fetch_count + COUNT_W'(1);
            if (imem_data == HALT_INSTR) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ifid_valid && ifid_ready) begin
            ifid_valid <= 1'b0;
            halted     <= 1'b1;
            state      <= HALTED;
          end
        end
        default: begin
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule
